// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array operand feeder.
package systolic_feeder_pkg;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Feed cycles needed to push N skewed operands through an N x N array.
   function automatic int FEED_LEN(input int n);
      return 3 * n - 2;
   endfunction

   // Bits needed to count 0..max_val, never fewer than one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/systolic_feeder_skew_buffer.sv
// N x N operand store, written one vector per beat, read back as the
// diagonal (skewed) vector for feed index t: element i = mem[t-i][i].
module skew_buffer
   import systolic_feeder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N     = 3
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [cnt_w(N-1)-1:0]       wr_idx,
   input  logic [N*WIDTH-1:0]          wr_data,
   input  logic [cnt_w(FEED_LEN(N)-1)-1:0] rd_t,
   output logic [N*WIDTH-1:0]          rd_data
);
   localparam int IW = cnt_w(N - 1);

   logic [N*WIDTH-1:0] mem [N];

   // NOTE: the operand store has no reset; a job always rewrites every entry before it is read.
   always_ff @(posedge clk) begin
      if (we) mem[wr_idx] <= wr_data;
   end

   // The same diagonal read serves A (stored by column) and B (stored by row).
   always_comb begin
      int d;
      d       = 0;
      rd_data = '0;
      for (int i = 0; i < N; i++) begin
         d = int'(rd_t) - i;
         if (d >= 0 && d < N) rd_data[i*WIDTH +: WIDTH] = mem[IW'(d)][i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A columns / B rows, then streams them skewed into an N x N systolic array.
// Optional ping-pong buffering: define SYSTOLIC_FEEDER_DOUBLE_BUF_EN.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int N            = 3,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] a_col,
   input  logic [N*WIDTH-1:0] b_row,
   output logic [N*WIDTH-1:0] row,
   output logic [N*WIDTH-1:0] col,
   output logic               acc_clr,
   output logic               busy,
   output logic               done
);
   localparam int IW = cnt_w(N - 1);
   localparam int TW = cnt_w(FEED_LEN(N) - 1);
   localparam int DW = cnt_w(DRAIN_CYCLES - 1);

   state_t          state, state_nx;
   logic            started;
   logic [IW-1:0]   beat_cnt;
   logic [TW-1:0]   feed_cnt;
   logic [DW-1:0]   drain_cnt;
   logic            accept, last_beat, feed_last, drain_last;
   logic            job_ready, next_ready;
   logic [TW-1:0]   rd_t;
   logic [N*WIDTH-1:0] a_skew, b_skew;

   assign accept     = in_valid && in_ready;
   assign last_beat  = accept && (beat_cnt == IW'(N - 1));
   assign feed_last  = (feed_cnt == TW'(FEED_LEN(N) - 1));
   assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES - 1));
   // Registered outputs are loaded one cycle ahead with the next feed index.
   assign rd_t       = (state == ST_FEED) ? feed_cnt + TW'(1) : '0;

`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
   logic               fill_sel, feed_sel;
   logic [1:0]         full;
   logic [N*WIDTH-1:0] a_rd0, a_rd1, b_rd0, b_rd1;

   assign in_ready   = started && !full[fill_sel];
   assign job_ready  = full[feed_sel] || (last_beat && (fill_sel == feed_sel));
   assign next_ready = full[!feed_sel] || (last_beat && (fill_sel != feed_sel));
   assign a_skew     = feed_sel ? a_rd1 : a_rd0;
   assign b_skew     = feed_sel ? b_rd1 : b_rd0;

   // Different banks: a bank being fed is full, so it is never the fill target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_sel <= 1'b0;
         feed_sel <= 1'b0;
         full     <= 2'b00;
      end else begin
         if (last_beat) begin
            full[fill_sel] <= 1'b1;
            fill_sel       <= !fill_sel;
         end
         if (state == ST_DONE) begin
            full[feed_sel] <= 1'b0;
            feed_sel       <= !feed_sel;
         end
      end
   end

   skew_buffer #(.WIDTH(WIDTH), .N(N)) u_a0 (.clk(clk), .we(accept && !fill_sel), .wr_idx(beat_cnt),
                                            .wr_data(a_col), .rd_t(rd_t), .rd_data(a_rd0));
   skew_buffer #(.WIDTH(WIDTH), .N(N)) u_a1 (.clk(clk), .we(accept && fill_sel), .wr_idx(beat_cnt),
                                            .wr_data(a_col), .rd_t(rd_t), .rd_data(a_rd1));
   skew_buffer #(.WIDTH(WIDTH), .N(N)) u_b0 (.clk(clk), .we(accept && !fill_sel), .wr_idx(beat_cnt),
                                            .wr_data(b_row), .rd_t(rd_t), .rd_data(b_rd0));
   skew_buffer #(.WIDTH(WIDTH), .N(N)) u_b1 (.clk(clk), .we(accept && fill_sel), .wr_idx(beat_cnt),
                                            .wr_data(b_row), .rd_t(rd_t), .rd_data(b_rd1));
`else
   assign in_ready   = started && (state == ST_LOAD);
   assign job_ready  = last_beat;
   assign next_ready = 1'b0;

   skew_buffer #(.WIDTH(WIDTH), .N(N)) u_a (.clk(clk), .we(accept), .wr_idx(beat_cnt),
                                           .wr_data(a_col), .rd_t(rd_t), .rd_data(a_skew));
   skew_buffer #(.WIDTH(WIDTH), .N(N)) u_b (.clk(clk), .we(accept), .wr_idx(beat_cnt),
                                           .wr_data(b_row), .rd_t(rd_t), .rd_data(b_skew));
`endif

   // NOTE: state_nx is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_LOAD:  if (job_ready) state_nx = ST_CLEAR;
         ST_CLEAR: state_nx = ST_FEED;
         ST_FEED:  if (feed_last) state_nx = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
         ST_DRAIN: if (drain_last) state_nx = ST_DONE;
         ST_DONE:  state_nx = next_ready ? ST_CLEAR : ST_LOAD;
         default:  state_nx = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_LOAD;
         started   <= 1'b0;
         beat_cnt  <= '0;
         feed_cnt  <= '0;
         drain_cnt <= '0;
         row       <= '0;
         col       <= '0;
      end else begin
         state   <= state_nx;
         started <= 1'b1;
         if (accept)            beat_cnt  <= last_beat ? '0 : beat_cnt + IW'(1);
         if (state == ST_FEED)  feed_cnt  <= feed_last ? '0 : feed_cnt + TW'(1);
         if (state == ST_DRAIN) drain_cnt <= drain_last ? '0 : drain_cnt + DW'(1);
         if (state == ST_CLEAR || (state == ST_FEED && !feed_last)) begin
            row <= a_skew;
            col <= b_skew;
         end else begin
            row <= '0;
            col <= '0;
         end
      end
   end

   assign acc_clr = (state == ST_CLEAR);
   assign busy    = (state == ST_CLEAR) || (state == ST_FEED) || (state == ST_DRAIN);
   assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder against a matrix-level model.
module tb_systolic_feeder;
   localparam int N  = 3;
   localparam int W  = 16;
   localparam int D  = 2;
   localparam int CW = 128;
   localparam int FL = 3 * N - 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] a_col, b_row, row, col;
   logic           acc_clr, busy, done;

   int checks = 0;
   int errors = 0;
   int ja [2][N][N];
   int jb [2][N][N];
   int row_h [64][N];
   int col_h [64][N];

   systolic_feeder #(.WIDTH(W), .N(N), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_col(a_col), .b_row(b_row), .row(row), .col(col),
      .acc_clr(acc_clr), .busy(busy), .done(done)
   );

   always #5 clk = !clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rand_op();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic rand_job(input int jn);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ja[jn][i][k] = rand_op();
            jb[jn][i][k] = rand_op();
         end
   endtask

   task automatic fill_job(input int jn, input int v);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ja[jn][i][k] = v;
            jb[jn][i][k] = v;
         end
   endtask

   // Skewed operand vector for feed cycle t straight from the matrix definition.
   function automatic logic [N*W-1:0] exp_vec(input int jn, input bit is_a, input int t);
      logic [N*W-1:0] v;
      int k;
      v = '0;
      for (int i = 0; i < N; i++) begin
         k = t - i;
         if (t >= 0 && t < FL && k >= 0 && k < N)
            v[i*W +: W] = is_a ? W'(ja[jn][i][k]) : W'(jb[jn][k][i]);
      end
      return v;
   endfunction

   task automatic junk(output logic [N*W-1:0] v);
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      v = t[N*W-1:0];
   endtask

   // Presents nbeats beats (optionally with idle gaps); returns just after the last accepting edge.
   task automatic load_job(input int jn, input bit gaps, input int nbeats);
      bit acc;
      for (int k = 0; k < nbeats; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               in_valid = 1'b0;
               junk(a_col);
               junk(b_row);
            end
         end
         @(negedge clk);
         in_valid = 1'b1;
         for (int i = 0; i < N; i++) begin
            a_col[i*W +: W] = W'(ja[jn][i][k]);
            b_row[i*W +: W] = W'(jb[jn][k][i]);
         end
         acc = 1'b0;
         for (int c = 0; c < 64 && !acc; c++) begin
            acc = in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
         end
         #1 in_valid = 1'b0;
         if (!acc) check("load_timeout", CW'(0), CW'(1));
      end
   endtask

   // Starts just after the edge entering CLEAR; ends at the negedge of the DONE cycle.
   task automatic watch_job(input int jn);
      int last_e;
      longint acc, ref_v;
      last_e = 3 * N - 1 + D;
      for (int e = 0; e <= last_e; e++) begin
         @(negedge clk);
         check("row", CW'(row), CW'(exp_vec(jn, 1'b1, e - 1)));
         check("col", CW'(col), CW'(exp_vec(jn, 1'b0, e - 1)));
         check("flags", CW'({acc_clr, busy, done}), CW'({e == 0, e < last_e, e == last_e}));
`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
         check("ready_busy", CW'(in_ready), CW'(0));
`endif
         for (int i = 0; i < N; i++) begin
            row_h[e][i] = int'($signed(row[i*W +: W]));
            col_h[e][i] = int'($signed(col[i*W +: W]));
         end
         if (e < last_e) @(posedge clk);
      end
      // Output-stationary array fed by the observed streams must produce A*B.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc = 0;
            ref_v = 0;
            for (int k = 0; k < N; k++) ref_v += longint'(ja[jn][i][k]) * longint'(jb[jn][k][j]);
            for (int t = 0; t < FL + 2 * N; t++)
               if (t - j >= 0 && t - j < FL && t - i >= 0 && t - i < FL)
                  acc += longint'(row_h[t - j + 1][i]) * longint'(col_h[t - i + 1][j]);
            check("array_c", CW'(acc), CW'(ref_v));
         end
   endtask

   task automatic post_done();
      @(posedge clk);
      @(negedge clk);
      check("idle_flags", CW'({acc_clr, busy, done}), CW'(0));
      check("idle_row", CW'(row), CW'(0));
      check("idle_ready", CW'(in_ready), CW'(1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_outs", CW'({row, col, acc_clr, busy, done, in_ready}), CW'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_ready_low", CW'(in_ready), CW'(0));
      @(posedge clk);
      #1 check("rst_ready_rise", CW'(in_ready), CW'(1));
   endtask

   task automatic run_checked_job(input bit gaps);
      load_job(0, gaps, N);
`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
      fork
         watch_job(0);
         begin
            // Beats offered while busy must be ignored.
            repeat (3 * N - 2) begin
               @(negedge clk);
               in_valid = 1'b1;
               junk(a_col);
               junk(b_row);
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
      join
`else
      watch_job(0);
`endif
      post_done();
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a_col    = '0;
      b_row    = '0;
      repeat (2) @(negedge clk);
      check("reset_state", CW'({row, col, acc_clr, busy, done, in_ready}), CW'(0));
      rst_n = 1'b1;
      #1 check("ready_before_edge", CW'(in_ready), CW'(0));
      @(posedge clk);
      #1 check("ready_after_edge", CW'(in_ready), CW'(1));

      // Directed job: A = 1..9 row-major, B = identity.
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ja[0][i][k] = i * N + k + 1;
            jb[0][i][k] = (i == k) ? 1 : 0;
         end
      run_checked_job(1'b0);

      for (int r = 0; r < 4; r++) begin
         rand_job(0);
         run_checked_job(1'b1);
      end

      fill_job(0, -32768);
      run_checked_job(1'b0);

      // Partial load abandoned by reset.
      rand_job(0);
      load_job(0, 1'b1, 2);
      do_reset();
      rand_job(0);
      run_checked_job(1'b1);

      // Reset during FEED at t=2.
      rand_job(0);
      load_job(0, 1'b0, N);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("feed_t2_row", CW'(row), CW'(exp_vec(0, 1'b1, 2)));
      check("feed_t2_col", CW'(col), CW'(exp_vec(0, 1'b0, 2)));
      #2 rst_n = 1'b0;
      #1 check("midjob_rst_outs", CW'({row, col, acc_clr, busy, done, in_ready}), CW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("midjob_ready_low", CW'(in_ready), CW'(0));
      @(posedge clk);
      #1 check("midjob_ready_rise", CW'(in_ready), CW'(1));
      rand_job(0);
      run_checked_job(1'b1);

`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
      // Back-to-back jobs: second is loaded while the first is streaming.
      rand_job(0);
      rand_job(1);
      load_job(0, 1'b0, N);
      fork
         begin
            watch_job(0);
            @(posedge clk);
            watch_job(1);
         end
         begin
            repeat (3) @(negedge clk);
            load_job(1, 1'b0, N);
         end
      join
      post_done();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
